rot_apb_regfile: RTL
====================

Name: rot_apb_regfile

Overview:
Parametrised second-generation APB slave register bank for the rotate engine, feeding the DMA and rotate core with image configuration.
- Adds configurable wait states and PSLVERR (unmapped, misaligned, read-only and busy-locked writes).
- Adds a self-clearing start pulse, a busy tracker, write-1-to-clear interrupt status with a mask, and a level interrupt output.

Parameters:
- ADDR_W, 12, PADDR width; only bits [7:0] are decoded, all higher bits must be zero.
- DATA_W, 32, APB data width (fixed at 32 in v2).
- DIM_W, 16, image height/width field width (1..16).
- WAIT_CYC, 0, PREADY-low cycles inserted in every access phase (0..15).

Ports:
- I_APBIF_PCLK  in  1  clock.
- I_APBIF_PRESET_N  in  1  reset; asynchronous assert, active-low.
- I_APBIF_PSEL  in  1  APB select.
- I_APBIF_PENABLE  in  1  APB enable.
- I_APBIF_PWRITE  in  1  1 = write.
- I_APBIF_PADDR  in  ADDR_W  byte address.
- I_APBIF_PWDATA  in  DATA_W  write data.
- I_APBIF_DMA_DST_IMG  in  32  destination address from the core.
- I_APBIF_ROT_IMG_NEW_H  in  DIM_W  rotated height.
- I_APBIF_ROT_IMG_NEW_W  in  DIM_W  rotated width.
- I_APBIF_DONE  in  1  single-cycle job-done pulse.
- I_APBIF_ERR  in  1  single-cycle job-error pulse.
- O_APBIF_PRDATA  out  DATA_W  read data.
- O_APBIF_PREADY  out  1  transfer complete.
- O_APBIF_PSLVERR  out  1  transfer error.
- O_APBIF_DMA_SRC_IMG  out  32  source address.
- O_APBIF_ROT_IMG_H  out  DIM_W  image height.
- O_APBIF_ROT_IMG_W  out  DIM_W  image width.
- O_APBIF_ROT_IMG_MODE  out  2  rotation mode.
- O_APBIF_ROT_IMG_DIR  out  1  direction.
- O_APBIF_CTRL_START  out  1  one-cycle start pulse.
- O_APBIF_CTRL_RESET  out  1  soft reset level.
- O_APBIF_BUSY  out  1  job in progress.
- O_APBIF_INTR  out  1  interrupt, level, registered.

Behaviour:
- Reset: all registers and outputs are 0 (PREADY, PSLVERR, PRDATA, START, BUSY, INTR included); INTR_MASK resets to 2'b11.
- Register map (offset, access, bits):
  - 0x00 SRC RW [31:0]
  - 0x04 DST RO, reads I_APBIF_DMA_DST_IMG
  - 0x08 H RW [DIM_W-1:0]
  - 0x0C W RW [DIM_W-1:0]
  - 0x10 NEW_H RO
  - 0x14 NEW_W RO
  - 0x18 MODE RW [1:0]
  - 0x1C DIR RW [0]
  - 0x20 START WO [0]
  - 0x24 SRESET RW [0]
  - 0x28 INTR_MASK RW [1:0]
  - 0x2C INTR_STAT W1C [1] err, [0] done
  - 0x30 STATUS RO [0] busy
- Unused bits read 0; writes to them are ignored. START reads 0.
- FSM states:
  - IDLE: PSEL=1, PENABLE=0 → SETUP.
  - SETUP → ACCESS; wait counter loaded with WAIT_CYC.
  - ACCESS: PREADY=0 while counter>0, decrement each cycle. When counter=0, drive PREADY=1 (registered, so PREADY rises the cycle after the counter hits 0; with WAIT_CYC=0, PREADY is high in the first ACCESS cycle), commit the write or drive PRDATA, → IDLE.
  - PSEL dropping mid-transfer → IDLE with no side effects.
- PRDATA holds its last value outside completed reads and is 0 on error reads.
- PSLVERR is asserted with PREADY when any of these holds:
  - address unmapped, >0x30, or any upper bit set;
  - PADDR[1:0] != 0;
  - write to an RO offset;
  - write to SRC/H/W/MODE/DIR while BUSY=1;
  - write to START with bit0=1 while BUSY=1.
- An errored write changes no state.
- START write with bit0=1 and BUSY=0: O_APBIF_CTRL_START high for exactly the cycle after PREADY, and BUSY is set in that same cycle.
- BUSY clears the cycle after I_APBIF_DONE or I_APBIF_ERR. SRESET=1 forces BUSY=0 and holds START low.
- INTR_STAT: DONE sets bit0, ERR sets bit1. A W1C write clears the bits written as 1. If a hardware set and a W1C land in the same cycle, the set wins.
- O_APBIF_INTR = registered |(INTR_STAT & INTR_MASK), i.e. one cycle of latency.
- Asynchronous reset mid-transfer aborts the transfer: FSM → IDLE, outputs → reset values.

Decomposition:
- Package rot_apb_pkg: register offset localparams, field widths, W1C bit indices, FSM state encoding.
- One sub-module, rot_apb_intr: status set/clear, mask and interrupt registering. FSM and decode stay in the top level.

Test Plan:
- WAIT_CYC=2; write 0x00=0xDEAD_BEEF then read 0x00 → PREADY low for exactly 2 access cycles, PRDATA=0xDEADBEEF, PSLVERR=0.
- Write 0x20=1 → START high for 1 cycle, BUSY=1. Write 0x08=0x40 → PSLVERR=1, H unchanged. Pulse DONE → BUSY=0, INTR_STAT=0x1, INTR=1 one cycle later.
- Write 0x2C=0x1 in the same cycle as a second DONE pulse → STAT bit0 stays 1. Later W1C with no event → STAT=0, INTR falls one cycle after.
- Read 0x34, read 0x02, write 0x10 → PSLVERR=1 each, PRDATA=0, no register changes.
- INTR_MASK=0x2, pulse DONE → INTR stays 0. Pulse ERR → INTR=1.
- Assert PRESET_N low during ACCESS with WAIT_CYC=3 → PREADY=0 and all registers 0 immediately (asynchronous); the next transfer completes normally.

Source files
------------

// File: rtl/rot_apb_pkg.sv
// Rotate-engine APB register bank: shared offsets, field widths
// and access FSM encoding.
package rot_apb_pkg;

    localparam int DEC_W  = 8;
    localparam int CNT_W  = 4;
    localparam int MODE_W = 2;
    localparam int IRQ_W  = 2;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;

    localparam logic [IRQ_W-1:0] MASK_RST = 2'b11;

    localparam logic [DEC_W-1:0] OFF_SRC       = 8'h00;
    localparam logic [DEC_W-1:0] OFF_DST       = 8'h04;
    localparam logic [DEC_W-1:0] OFF_H         = 8'h08;
    localparam logic [DEC_W-1:0] OFF_W         = 8'h0C;
    localparam logic [DEC_W-1:0] OFF_NEW_H     = 8'h10;
    localparam logic [DEC_W-1:0] OFF_NEW_W     = 8'h14;
    localparam logic [DEC_W-1:0] OFF_MODE      = 8'h18;
    localparam logic [DEC_W-1:0] OFF_DIR       = 8'h1C;
    localparam logic [DEC_W-1:0] OFF_START     = 8'h20;
    localparam logic [DEC_W-1:0] OFF_SRESET    = 8'h24;
    localparam logic [DEC_W-1:0] OFF_INTR_MASK = 8'h28;
    localparam logic [DEC_W-1:0] OFF_INTR_STAT = 8'h2C;
    localparam logic [DEC_W-1:0] OFF_STATUS    = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_e;

endpackage

// File: rtl/rot_apb_intr.sv
// Interrupt status (hardware set, W1C clear), mask and the
// registered level interrupt.
module rot_apb_intr
    import rot_apb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done,
    input  logic             err,
    input  logic             w1c_en,
    input  logic [IRQ_W-1:0] w1c_bits,
    input  logic             mask_we,
    input  logic [IRQ_W-1:0] mask_bits,
    output logic [IRQ_W-1:0] stat,
    output logic [IRQ_W-1:0] mask,
    output logic             intr
);

    logic [IRQ_W-1:0] set_bits;
    logic [IRQ_W-1:0] clr_bits;

    always_comb begin
        set_bits            = '0;
        set_bits[STAT_DONE] = done;
        set_bits[STAT_ERR]  = err;
        clr_bits            = w1c_en ? w1c_bits : '0;
    end

    // Set is OR-ed in after the clear so a coincident event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat <= '0;
            mask <= MASK_RST;
            intr <= 1'b0;
        end else begin
            stat <= (stat & ~clr_bits) | set_bits;
            if (mask_we) begin
                mask <= mask_bits;
            end
            intr <= |(stat & mask);
        end
    end

endmodule

// File: rtl/rot_apb_regfile.sv
// APB slave register bank for the rotate engine: wait states,
// PSLVERR, start/busy tracking and interrupt status.
module rot_apb_regfile
    import rot_apb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int DIM_W    = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic              I_APBIF_PCLK,
    input  logic              I_APBIF_PRESET_N,
    input  logic              I_APBIF_PSEL,
    input  logic              I_APBIF_PENABLE,
    input  logic              I_APBIF_PWRITE,
    input  logic [ADDR_W-1:0] I_APBIF_PADDR,
    input  logic [DATA_W-1:0] I_APBIF_PWDATA,
    input  logic [31:0]       I_APBIF_DMA_DST_IMG,
    input  logic [DIM_W-1:0]  I_APBIF_ROT_IMG_NEW_H,
    input  logic [DIM_W-1:0]  I_APBIF_ROT_IMG_NEW_W,
    input  logic              I_APBIF_DONE,
    input  logic              I_APBIF_ERR,
    output logic [DATA_W-1:0] O_APBIF_PRDATA,
    output logic              O_APBIF_PREADY,
    output logic              O_APBIF_PSLVERR,
    output logic [31:0]       O_APBIF_DMA_SRC_IMG,
    output logic [DIM_W-1:0]  O_APBIF_ROT_IMG_H,
    output logic [DIM_W-1:0]  O_APBIF_ROT_IMG_W,
    output logic [1:0]        O_APBIF_ROT_IMG_MODE,
    output logic              O_APBIF_ROT_IMG_DIR,
    output logic              O_APBIF_CTRL_START,
    output logic              O_APBIF_CTRL_RESET,
    output logic              O_APBIF_BUSY,
    output logic              O_APBIF_INTR
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);
    localparam bit               NO_WAIT = (WAIT_CYC == 0);

    apb_state_e        state;
    logic [CNT_W-1:0]  cnt;

    logic [31:0]       src_q;
    logic [DIM_W-1:0]  h_q;
    logic [DIM_W-1:0]  w_q;
    logic [MODE_W-1:0] mode_q;
    logic              dir_q;
    logic              sreset_q;
    logic              start_req;
    logic              start_q;
    logic              busy_q;

    logic [IRQ_W-1:0]  stat;
    logic [IRQ_W-1:0]  mask;

    logic [DEC_W-1:0]  off;
    logic              hi_bad;
    logic              misal;
    logic              mapped;
    logic              ro;
    logic              lock;
    logic [DATA_W-1:0] rd_data;
    logic              acc_err;
    logic              fin;
    logic              commit;
    logic              wr_ok;

    assign off    = I_APBIF_PADDR[DEC_W-1:0];
    assign hi_bad = |(I_APBIF_PADDR >> DEC_W);
    assign misal  = |off[1:0];

    // lock marks fields that may not be written while a job runs.
    always_comb begin
        rd_data = '0;
        mapped  = 1'b1;
        ro      = 1'b0;
        lock    = 1'b0;
        case (off)
            OFF_SRC: begin
                rd_data = DATA_W'(src_q);
                lock    = 1'b1;
            end
            OFF_DST: begin
                rd_data = DATA_W'(I_APBIF_DMA_DST_IMG);
                ro      = 1'b1;
            end
            OFF_H: begin
                rd_data = DATA_W'(h_q);
                lock    = 1'b1;
            end
            OFF_W: begin
                rd_data = DATA_W'(w_q);
                lock    = 1'b1;
            end
            OFF_NEW_H: begin
                rd_data = DATA_W'(I_APBIF_ROT_IMG_NEW_H);
                ro      = 1'b1;
            end
            OFF_NEW_W: begin
                rd_data = DATA_W'(I_APBIF_ROT_IMG_NEW_W);
                ro      = 1'b1;
            end
            OFF_MODE: begin
                rd_data = DATA_W'(mode_q);
                lock    = 1'b1;
            end
            OFF_DIR: begin
                rd_data = DATA_W'(dir_q);
                lock    = 1'b1;
            end
            OFF_START: begin
                lock = I_APBIF_PWDATA[0];
            end
            OFF_SRESET: begin
                rd_data = DATA_W'(sreset_q);
            end
            OFF_INTR_MASK: begin
                rd_data = DATA_W'(mask);
            end
            OFF_INTR_STAT: begin
                rd_data = DATA_W'(stat);
            end
            OFF_STATUS: begin
                rd_data = DATA_W'(busy_q);
                ro      = 1'b1;
            end
            default: begin
                mapped = 1'b0;
            end
        endcase
    end

    assign acc_err = hi_bad | misal | ~mapped
                   | (I_APBIF_PWRITE & (ro | (lock & busy_q)));

    assign fin = (state == ST_SETUP && NO_WAIT)
              || (state == ST_ACCESS && cnt == CNT_W'(1));

    assign commit = I_APBIF_PSEL & fin;
    assign wr_ok  = commit & I_APBIF_PWRITE & ~acc_err;

    always_ff @(posedge I_APBIF_PCLK or negedge I_APBIF_PRESET_N) begin
        if (!I_APBIF_PRESET_N) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            O_APBIF_PREADY  <= 1'b0;
            O_APBIF_PSLVERR <= 1'b0;
            O_APBIF_PRDATA  <= '0;
        end else begin
            O_APBIF_PREADY  <= 1'b0;
            O_APBIF_PSLVERR <= 1'b0;
            if (commit) begin
                O_APBIF_PREADY  <= 1'b1;
                O_APBIF_PSLVERR <= acc_err;
                if (!I_APBIF_PWRITE) begin
                    O_APBIF_PRDATA <= acc_err ? '0 : rd_data;
                end
            end
            unique case (state)
                ST_IDLE: begin
                    if (I_APBIF_PSEL && !I_APBIF_PENABLE) begin
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!I_APBIF_PSEL) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_ACCESS;
                        cnt   <= WAIT_LD;
                    end
                end
                ST_ACCESS: begin
                    if (!I_APBIF_PSEL || cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I_APBIF_PCLK or negedge I_APBIF_PRESET_N) begin
        if (!I_APBIF_PRESET_N) begin
            src_q     <= '0;
            h_q       <= '0;
            w_q       <= '0;
            mode_q    <= '0;
            dir_q     <= 1'b0;
            sreset_q  <= 1'b0;
            start_req <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            start_req <= wr_ok && off == OFF_START && I_APBIF_PWDATA[0];
            if (wr_ok) begin
                case (off)
                    OFF_SRC:    src_q    <= I_APBIF_PWDATA[31:0];
                    OFF_H:      h_q      <= I_APBIF_PWDATA[DIM_W-1:0];
                    OFF_W:      w_q      <= I_APBIF_PWDATA[DIM_W-1:0];
                    OFF_MODE:   mode_q   <= I_APBIF_PWDATA[MODE_W-1:0];
                    OFF_DIR:    dir_q    <= I_APBIF_PWDATA[0];
                    OFF_SRESET: sreset_q <= I_APBIF_PWDATA[0];
                    default: ;
                endcase
            end
            // Start pulse and busy launch one cycle after the write completes.
            if (sreset_q) begin
                start_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                start_q <= start_req;
                if (start_req) begin
                    busy_q <= 1'b1;
                end else if (I_APBIF_DONE || I_APBIF_ERR) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    rot_apb_intr u_intr (
        .clk       (I_APBIF_PCLK),
        .rst_n     (I_APBIF_PRESET_N),
        .done      (I_APBIF_DONE),
        .err       (I_APBIF_ERR),
        .w1c_en    (wr_ok && off == OFF_INTR_STAT),
        .w1c_bits  (I_APBIF_PWDATA[IRQ_W-1:0]),
        .mask_we   (wr_ok && off == OFF_INTR_MASK),
        .mask_bits (I_APBIF_PWDATA[IRQ_W-1:0]),
        .stat      (stat),
        .mask      (mask),
        .intr      (O_APBIF_INTR)
    );

    assign O_APBIF_DMA_SRC_IMG  = src_q;
    assign O_APBIF_ROT_IMG_H    = h_q;
    assign O_APBIF_ROT_IMG_W    = w_q;
    assign O_APBIF_ROT_IMG_MODE = mode_q;
    assign O_APBIF_ROT_IMG_DIR  = dir_q;
    assign O_APBIF_CTRL_START   = start_q;
    assign O_APBIF_CTRL_RESET   = sreset_q;
    assign O_APBIF_BUSY         = busy_q;

endmodule
